// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control beside the ID/EXE register: tracks EXE and MEM writers, emits operand selects.
// Latency: selects, exe_valid and stall_cnt registered (1 cycle); stall is combinational from current ID and slots.
// Backpressure: load-use (or any RAW with forwarding off) holds ID via stall; flush overrides stall with a bubble.
module hazard_fwd_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             id_two_src,
  input  logic             id_is_store,
  output logic             stall,
  output logic             exe_valid,
  output logic [1:0]       val1_sel,
  output logic [1:0]       val2_sel,
  output logic [1:0]       ST_val_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  // Only the EXE and MEM writers can create hazards: the register file writes
  // through during WB, so the WB stage never needs to be tracked here.
  logic             e_vld, e_wb, e_mr;
  logic [REG_W-1:0] e_dest;
  logic             m_vld, m_wb;
  logic [REG_W-1:0] m_dest;

  // A slot "writes r" only if it is a real writing instruction and r is not r0.
  function automatic logic writes(input logic v, input logic wb,
                                  input logic [REG_W-1:0] d,
                                  input logic [REG_W-1:0] r);
    return v & wb & (d == r) & (r != '0);
  endfunction

  logic       e_w1, m_w1, e_w2, m_w2;
  logic       use2, load_use, raw_any, issue;
  logic [1:0] sel1, sel2;

  // Hazard detection and next-cycle select computation for the ID instruction.
  always_comb begin
    e_w1     = writes(e_vld, e_wb, e_dest, id_src1);
    m_w1     = writes(m_vld, m_wb, m_dest, id_src1);
    e_w2     = writes(e_vld, e_wb, e_dest, id_src2);
    m_w2     = writes(m_vld, m_wb, m_dest, id_src2);
    use2     = id_two_src;
    // Youngest writer (EXE) takes priority over MEM.
    sel1     = e_w1 ? 2'd1 : (m_w1 ? 2'd2 : 2'd0);
    sel2     = e_w2 ? 2'd1 : (m_w2 ? 2'd2 : 2'd0);
    load_use = e_mr & (e_w1 | (use2 & e_w2));
    raw_any  = e_w1 | m_w1 | (use2 & (e_w2 | m_w2));
    stall    = id_valid & ~flush & (load_use | (~fwd_en & raw_any));
    issue    = id_valid & ~stall & ~flush;
  end

  // Shadow slot advance: MEM takes EXE, EXE takes the issued instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_vld  <= 1'b0;
      e_wb   <= 1'b0;
      e_mr   <= 1'b0;
      e_dest <= '0;
      m_vld  <= 1'b0;
      m_wb   <= 1'b0;
      m_dest <= '0;
    end else begin
      m_vld  <= e_vld;
      m_wb   <= e_wb;
      m_dest <= e_dest;
      e_vld  <= issue;
      e_wb   <= issue & id_wb_en;
      e_mr   <= issue & id_mem_read;
      e_dest <= issue ? id_dest : '0;
    end
  end

  // Registered selects for the EXE cycle; bubbles and forwarding-off force zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid  <= 1'b0;
      val1_sel   <= 2'd0;
      val2_sel   <= 2'd0;
      ST_val_sel <= 2'd0;
    end else begin
      exe_valid  <= issue;
      val1_sel   <= (issue & fwd_en) ? sel1 : 2'd0;
      val2_sel   <= (issue & fwd_en & use2 & ~id_is_store) ? sel2 : 2'd0;
      ST_val_sel <= (issue & fwd_en & use2 & id_is_store) ? sel2 : 2'd0;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
